vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_if.sv | 14 +
 rtl/vga_timing_gen.sv | 90 +++++++++
 tb/tb_vga_timing_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Scan-out bundle from the VGA timing generator to the drawing blocks.
// The generator drives it through the master modport; consumers use the slave modport.
interface vga_timing_gen_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (output DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count);
endinterface

// File: rtl/vga_timing_gen.sv
// Pixel-rate VGA raster counters with delayed blank/sync, a frame strobe and a frame counter.
// blank/hs/vs trail DrawX/DrawY by PIPE_DELAY clocks to match the drawers' registered colour.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int PIPE_DELAY = 2
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [9:0] HC_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] VC_MAX = 10'(V_TOTAL - 1);

    // Stage layout is {blank, hs, vs}; idle is blank off with both syncs released high.
    localparam logic [2:0] PIPE_IDLE = 3'b011;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_cfg
            $error("vga_timing_gen: totals must be <= 1024 and PIPE_DELAY within 1..8");
        end
    endgenerate

    logic [9:0]                  r_hc;
    logic [9:0]                  r_vc;
    logic [PIPE_DELAY-1:0][2:0]  r_pipe;
    logic                        r_frame_start;
    logic [7:0]                  r_frame_count;

    logic       w_h_end;
    logic       w_v_end;
    logic       w_blank_raw;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic [2:0] w_raw;

    assign w_h_end = (r_hc == HC_MAX);
    assign w_v_end = (r_vc == VC_MAX);

    assign w_blank_raw = (int'(r_hc) < H_VISIBLE) && (int'(r_vc) < V_VISIBLE);
    assign w_hs_raw    = !((int'(r_hc) >= H_SYNC_START) && (int'(r_hc) < H_SYNC_END));
    // vc only moves at the line wrap, so vs is naturally line-granular.
    assign w_vs_raw    = !((int'(r_vc) >= V_SYNC_START) && (int'(r_vc) < V_SYNC_END));
    assign w_raw       = {w_blank_raw, w_hs_raw, w_vs_raw};

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc          <= '0;
            r_vc          <= '0;
            r_pipe        <= {PIPE_DELAY{PIPE_IDLE}};
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_hc <= w_h_end ? '0 : r_hc + 10'd1;
            if (w_h_end) begin
                r_vc <= w_v_end ? '0 : r_vc + 10'd1;
            end
            // Strobe lands with the counters at (0,0) after a real wrap, never after reset.
            r_frame_start <= w_h_end && w_v_end;
            if (w_h_end && w_v_end) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
            r_pipe[0] <= w_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign vif.DrawX       = r_hc;
    assign vif.DrawY       = r_vc;
    assign vif.blank       = r_pipe[PIPE_DELAY-1][2];
    assign vif.hs          = r_pipe[PIPE_DELAY-1][1];
    assign vif.vs          = r_pipe[PIPE_DELAY-1][0];
    assign vif.frame_start = r_frame_start;
    assign vif.frame_count = r_frame_count;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed-vector bench: default 640x480 timing on one instance, a tiny 12x7 raster
// with PIPE_DELAY=1 on a second instance for frame wrap and frame_count rollover.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();

    vga_timing_gen u_dut_a (
        .vga_clk (clk),
        .reset_n (rst_a),
        .vif     (ifa)
    );

    vga_timing_gen #(
        .H_VISIBLE (8), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .PIPE_DELAY(1)
    ) u_dut_b (
        .vga_clk (clk),
        .reset_n (rst_b),
        .vif     (ifb)
    );

    typedef struct {
        int         n;
        logic [9:0] x;
        logic [9:0] y;
        logic       b;
        logic       h;
        logic       v;
        logic       fs;
        logic [7:0] fc;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    function automatic logic [31:0] pk(logic [9:0] x, logic [9:0] y, logic b, logic h,
                                       logic v, logic fs, logic [7:0] fc);
        return {x, y, b, h, v, fs, fc};
    endfunction

    function automatic vec_t mk(int nn, int x, int y, logic b, logic h, logic v,
                                logic fs, int fc);
        vec_t r;
        r.n = nn; r.x = 10'(x); r.y = 10'(y);
        r.b = b; r.h = h; r.v = v; r.fs = fs; r.fc = 8'(fc);
        return r;
    endfunction

    logic [31:0] act_a;
    logic [31:0] act_b;
    assign act_a = pk(ifa.DrawX, ifa.DrawY, ifa.blank, ifa.hs, ifa.vs, ifa.frame_start, ifa.frame_count);
    assign act_b = pk(ifb.DrawX, ifb.DrawY, ifb.blank, ifb.hs, ifb.vs, ifb.frame_start, ifb.frame_count);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got X=%0d Y=%0d b/hs/vs/fs=%b fc=%0d, want X=%0d Y=%0d b/hs/vs/fs=%b fc=%0d",
                     nm, act[31:22], act[21:12], act[11:8], act[7:0],
                     exp[31:22], exp[21:12], exp[11:8], exp[7:0]);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Advance to 'target' clock edges after reset release, then sample 2 ns after the edge.
    task automatic adv(input int target);
        while (n < target) begin
            @(posedge clk);
            n++;
        end
        #2;
    endtask

    function automatic logic [31:0] vpk(vec_t v);
        return pk(v.x, v.y, v.b, v.h, v.v, v.fs, v.fc);
    endfunction

    vec_t va[$];
    vec_t vb[$];
    logic [31:0] rst_vals;

    initial begin
        int fs_cnt;
        int lo_cnt;
        int hi_cnt;

        rst_vals = pk(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

        // Default timing: n = clock edges since release; blank/hs/vs reflect counters at n-2.
        va.push_back(mk(  0,   0, 0, 0, 1, 1, 0, 0));
        va.push_back(mk(  1,   1, 0, 0, 1, 1, 0, 0));
        va.push_back(mk(  2,   2, 0, 1, 1, 1, 0, 0));
        va.push_back(mk(641, 641, 0, 1, 1, 1, 0, 0));
        va.push_back(mk(642, 642, 0, 0, 1, 1, 0, 0));
        va.push_back(mk(657, 657, 0, 0, 1, 1, 0, 0));
        va.push_back(mk(658, 658, 0, 0, 0, 1, 0, 0));
        va.push_back(mk(753, 753, 0, 0, 0, 1, 0, 0));
        va.push_back(mk(754, 754, 0, 0, 1, 1, 0, 0));
        va.push_back(mk(799, 799, 0, 0, 1, 1, 0, 0));
        va.push_back(mk(800,   0, 1, 0, 1, 1, 0, 0));
        va.push_back(mk(801,   1, 1, 0, 1, 1, 0, 0));
        va.push_back(mk(802,   2, 1, 1, 1, 1, 0, 0));

        // Small raster 12x7, one clock lag: sync at hc 9..10, vs on line 5.
        vb.push_back(mk(    0,  0, 0, 0, 1, 1, 0, 0));
        vb.push_back(mk(    1,  1, 0, 1, 1, 1, 0, 0));
        vb.push_back(mk(    8,  8, 0, 1, 1, 1, 0, 0));
        vb.push_back(mk(    9,  9, 0, 0, 1, 1, 0, 0));
        vb.push_back(mk(   10, 10, 0, 0, 0, 1, 0, 0));
        vb.push_back(mk(   11, 11, 0, 0, 0, 1, 0, 0));
        vb.push_back(mk(   12,  0, 1, 0, 1, 1, 0, 0));
        vb.push_back(mk(   13,  1, 1, 1, 1, 1, 0, 0));
        vb.push_back(mk(   60,  0, 5, 0, 1, 1, 0, 0));
        vb.push_back(mk(   61,  1, 5, 0, 1, 0, 0, 0));
        vb.push_back(mk(   72,  0, 6, 0, 1, 0, 0, 0));
        vb.push_back(mk(   73,  1, 6, 0, 1, 1, 0, 0));
        vb.push_back(mk(   83, 11, 6, 0, 0, 1, 0, 0));
        vb.push_back(mk(   84,  0, 0, 0, 1, 1, 1, 1));
        vb.push_back(mk(   85,  1, 0, 1, 1, 1, 0, 1));
        vb.push_back(mk(  168,  0, 0, 0, 1, 1, 1, 2));
        vb.push_back(mk(  169,  1, 0, 1, 1, 1, 0, 2));
        vb.push_back(mk(21504,  0, 0, 0, 1, 1, 1, 0));
        vb.push_back(mk(21505,  1, 0, 1, 1, 1, 0, 0));

        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_a", act_a, rst_vals);
        chk("reset_b", act_b, rst_vals);

        // ---- default instance ----
        @(negedge clk);
        rst_a = 1'b1;
        n = 0;
        foreach (va[i]) begin
            adv(va[i].n);
            chk($sformatf("a_vec%0d_n%0d", i, va[i].n), act_a, vpk(va[i]));
        end

        // Whole of line 1 (delayed view): hs low for 96 clocks, blank high for 640.
        lo_cnt = 0;
        hi_cnt = 0;
        for (int k = 803; k <= 1602; k++) begin
            adv(k);
            if (ifa.hs == 1'b0) lo_cnt++;
            if (ifa.blank == 1'b1) hi_cnt++;
        end
        chk_int("a_hs_low_width", lo_cnt, 96);
        chk_int("a_blank_width", hi_cnt, 640);

        // Mid-line reset while hs is low at DrawX=700.
        adv(2300);
        chk("a_pre_midreset", act_a, pk(10'd700, 10'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));
        #1 rst_a = 1'b0;
        #1 chk("a_async_reset", act_a, rst_vals);
        repeat (2) @(negedge clk);
        rst_a = 1'b1;
        n = 0;
        adv(3);
        chk("a_resume_3", act_a, pk(10'd3, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0));
        adv(658);
        chk("a_resume_658", act_a, pk(10'd658, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0));

        // ---- small instance ----
        @(negedge clk);
        rst_b = 1'b1;
        n = 0;
        foreach (vb[i]) begin
            adv(vb[i].n);
            chk($sformatf("b_vec%0d_n%0d", i, vb[i].n), act_b, vpk(vb[i]));
        end

        // One further frame: a single strobe and 12 clocks of vs low.
        fs_cnt = 0;
        lo_cnt = 0;
        for (int k = 21506; k <= 21589; k++) begin
            adv(k);
            if (ifb.frame_start == 1'b1) fs_cnt++;
            if (ifb.vs == 1'b0) lo_cnt++;
        end
        chk_int("b_fs_per_frame", fs_cnt, 1);
        chk_int("b_vs_low_width", lo_cnt, 12);

        adv(21598);
        chk("b_pre_midreset", act_b, pk(10'd10, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1));
        #1 rst_b = 1'b0;
        #1 chk("b_async_reset", act_b, rst_vals);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        n = 0;
        adv(1);
        chk("b_resume_1", act_b, pk(10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0));
        adv(84);
        chk("b_resume_frame", act_b, pk(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'd1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
